// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: collects a byte stream into 512-bit blocks, appends
// the 0x80 marker, zero fill and the 64-bit big-endian bit-length, and hands
// the blocks to the hash engine with a final-block flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ACCEPT   | taking message bytes into the block buffer
// EMIT     | presenting a data-bearing block, waiting for blk_ready_i
// EMIT_LEN | presenting the trailing length-only block (always final)
module sha256_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [7:0]   in_data_i,
    input  logic         in_valid_i,
    input  logic         in_last_i,
    output logic         in_ready_o,
    output logic [511:0] blk_data_o,
    output logic         blk_valid_o,
    output logic         blk_last_o,
    input  logic         blk_ready_i,
    output logic         busy_o,
    output logic         len_err_o
);

    typedef enum logic [1:0] {
        ACCEPT   = 2'd0,
        EMIT     = 2'd1,
        EMIT_LEN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [511:0]       buf_q, buf_d;
    logic [5:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               last_q, last_d;
    logic               len_pend_q, len_pend_d;   // a length-only block must follow
    logic               pad80_q, pad80_d;         // that block starts with 0x80
    logic               busy_q, busy_d;
    logic               len_err_q, len_err_d;

    logic               accept;
    logic               handshake;
    logic [8:0]         wr_base;
    logic [8:0]         nxt_base;
    logic [LEN_W-1:0]   count_inc;

    // Bit-length field: byte count times eight, zero-extended to 64 bits.
    function automatic logic [63:0] len_field(input logic [LEN_W-1:0] c);
        logic [63:0] f;
        f = '0;
        f[LEN_W+2:3] = c;
        return f;
    endfunction

    assign accept    = (state_q == ACCEPT) && in_valid_i;
    assign handshake = (state_q != ACCEPT) && blk_ready_i;
    assign wr_base   = 9'd511 - {idx_q, 3'b000};
    assign nxt_base  = wr_base - 9'd8;
    assign count_inc = count_q + 1'b1;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT: begin
                if (accept && (in_last_i || idx_q == 6'd63)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (blk_ready_i) begin
                    if (last_q) begin
                        state_d = ACCEPT;
                    end else if (len_pend_q) begin
                        state_d = EMIT_LEN;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            EMIT_LEN: begin
                if (blk_ready_i) begin
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    // Output decode; both handshake outputs come straight from the state register.
    always_comb begin
        in_ready_o  = (state_q == ACCEPT);
        blk_valid_o = (state_q != ACCEPT);
        blk_data_o  = buf_q;
        blk_last_o  = last_q;
        busy_o      = busy_q;
        len_err_o   = len_err_q;
    end

    // Datapath next-state: byte writes, padding and block turnover.
    // Slots past idx are always zero because the buffer is cleared after each
    // block, so padding only needs the 0x80 marker and the length.
    always_comb begin
        buf_d      = buf_q;
        idx_d      = idx_q;
        count_d    = count_q;
        last_d     = last_q;
        len_pend_d = len_pend_q;
        pad80_d    = pad80_q;
        busy_d     = busy_q;
        len_err_d  = len_err_q;

        if (accept) begin
            buf_d[wr_base -: 8] = in_data_i;
            idx_d      = idx_q + 6'd1;
            count_d    = count_inc;
            busy_d     = 1'b1;
            last_d     = 1'b0;
            len_pend_d = 1'b0;
            pad80_d    = 1'b0;
            if (&count_q) begin
                len_err_d = 1'b1;
            end
            if (in_last_i) begin
                if (idx_q != 6'd63) begin
                    buf_d[nxt_base -: 8] = 8'h80;
                end
                if (idx_q <= 6'd54) begin
                    buf_d[63:0] = len_field(count_inc);
                    last_d      = 1'b1;
                end else if (idx_q == 6'd63) begin
                    len_pend_d = 1'b1;
                    pad80_d    = 1'b1;
                end else begin
                    len_pend_d = 1'b1;
                end
            end
        end else if (handshake) begin
            if (last_q) begin
                buf_d      = '0;
                idx_d      = '0;
                count_d    = '0;
                busy_d     = 1'b0;
                last_d     = 1'b0;
                len_pend_d = 1'b0;
                pad80_d    = 1'b0;
            end else if (len_pend_q) begin
                buf_d      = {(pad80_q ? 8'h80 : 8'h00), 440'd0, len_field(count_q)};
                last_d     = 1'b1;
                len_pend_d = 1'b0;
            end else begin
                buf_d = '0;
                idx_d = '0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buf_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            last_q     <= 1'b0;
            len_pend_q <= 1'b0;
            pad80_q    <= 1'b0;
            busy_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            last_q     <= last_d;
            len_pend_q <= len_pend_d;
            pad80_q    <= pad80_d;
            busy_q     <= busy_d;
            len_err_q  <= len_err_d;
        end
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 state machine.
- Accepts an arbitrary-length message as a byte stream with a valid/ready handshake.
- Applies FIPS 180-4 padding: a 0x80 byte, then zero bytes, then the 64-bit big-endian bit-length.
- Emits one or more 512-bit blocks on a valid/ready block interface, flagging the final block so the downstream hash engine knows when to finalise the digest.

Parameters:
- LEN_W, 32: width of the internal message byte counter; the bit-length field is {zeros, count, 3'b000} in 64 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  message byte.
- in_valid  input  1  in_data is valid.
- in_last  input  1  qualifies in_valid; marks the final message byte.
- in_ready  output  1  padder accepts a byte this cycle.
- blk_data  output  512  padded block; message byte 0 sits at [511:504].
- blk_valid  output  1  blk_data is valid.
- blk_last  output  1  qualifies blk_valid; marks the final block of the message.
- blk_ready  input  1  downstream accepts the block.
- busy  output  1  a message is in progress; high from the first byte accepted until the final block handshake.
- len_err  output  1  sticky; byte counter wrapped past 2^LEN_W-1.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high. Asserting reset clears all state immediately.
- Reset values:
  - in_ready = 1 after reset deasserts; blk_valid = 0; blk_last = 0; busy = 0; len_err = 0.
  - blk_data = 0; byte index idx = 0; byte count = 0.
- States: ACCEPT, EMIT, EMIT_LEN.
- ACCEPT:
  - in_ready = 1. On in_valid & in_ready, write the byte at slot idx, idx++, count++. One byte per cycle is sustainable.
  - Non-last byte filling slot 63: go to EMIT with blk_last = 0.
  - Last byte written at slot k, so k+1 bytes of this block are used. In the same clock edge:
    - If k <= 54: write 0x80 at slot k+1, zero slots k+2..55, write the length into slots 56..63, blk_last = 1, go to EMIT.
    - If 55 <= k <= 62: write 0x80 at slot k+1, zero the rest, blk_last = 0, go to EMIT, then EMIT_LEN.
    - If k == 63: blk_last = 0, go to EMIT, then EMIT_LEN with 0x80 at slot 0.
- Latency: blk_valid rises the cycle after the handshake of the byte that completes the block or ends the message.
- EMIT:
  - in_ready = 0; blk_valid = 1. blk_data and blk_last are held stable until blk_ready.
  - On the handshake:
    - If blk_last: return to ACCEPT, clear idx/count/buffer, busy = 0.
    - Else if the message ended: load the length-only block, go to EMIT_LEN.
    - Else: clear the buffer, idx = 0, return to ACCEPT.
- EMIT_LEN:
  - blk_data = optional 0x80 at slot 0, zeros, length in [63:0]; blk_last = 1.
  - Behaves as EMIT with blk_last = 1; the next block is presented the cycle after the previous handshake.
- Length field = count * 8, zero-extended to 64 bits, big-endian.
- Counter wrap: count wraps modulo 2^LEN_W and len_err sets sticky until reset. Padding continues with the wrapped count.
- in_ready is registered low for the whole of EMIT/EMIT_LEN; input bytes offered then are not consumed.
- Empty messages are unsupported; every message carries at least one byte (in_last always coincides with a valid byte).
- Reset mid-message or mid-block: block dropped, partial message discarded, next byte starts a new message.

Test Plan:
- "hello world" (11 bytes, last on 'd'):
  - Required response: one block 68656c6c6f20776f726c6480 followed by zeros, tail 0x58; blk_last = 1; blk_valid the cycle after the last byte.
  - Chained into sha256_state_machine, the digest is b94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9.
- 55 bytes of 0x61:
  - Single block: 0x80 at slot 55, length 0x1B8, blk_last = 1.
- 56 bytes of 0x61:
  - Block 1: 0x80 at slot 56, slots 57..63 zero, blk_last = 0.
  - Block 2: all zero except length 0x1C0, blk_last = 1.
- 64 bytes of 0x61:
  - Block 1: pure data, blk_last = 0.
  - Block 2: 0x80 at [511:504], length 0x200, blk_last = 1.
- 11-byte message, blk_ready held low 5 cycles:
  - blk_valid and blk_data stay stable; in_ready = 0 throughout.
  - Handshake on cycle 6; in_ready returns high the next cycle.
- Reset asserted after 20 bytes, then "abc" sent:
  - Outputs clear immediately.
  - Single block 61626380 followed by zeros, length 0x18; no residue from the first 20 bytes.
